// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings, FSM states, lane geometry.
package lsu_pkg;

  localparam int LANES = 4;
  localparam int BYTE  = 8;

  typedef enum logic [2:0] {
    CTRL_B  = 3'b000,
    CTRL_H  = 3'b001,
    CTRL_W  = 3'b010,
    CTRL_BU = 3'b100,
    CTRL_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic ctrl_legal(input logic [2:0] ctrl, input logic we);
    case (ctrl)
      CTRL_B, CTRL_H, CTRL_W: return 1'b1;
      CTRL_BU, CTRL_HU:       return !we;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store-data shifting for up to two beats,
// plus load-data merge across beats and sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic        split,
  output logic [31:0] load_data
);

  logic [2:0]  nbytes;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [63:0] rdata_wide;
  logic [31:0] shifted;

  // Work on an 8-lane window so a crossing access falls naturally into two words.
  always_comb begin
    nbytes     = size_bytes(ctrl);
    be_wide    = ((8'd1 << nbytes) - 8'd1) << offset;
    wdata_wide = {32'd0, wdata} << {offset, 3'b000};
    rdata_wide = {rdata_hi, rdata_lo} >> {offset, 3'b000};
    shifted    = rdata_wide[31:0];
    case (nbytes)
      3'd1:    load_data = ctrl[2] ? {24'd0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      3'd2:    load_data = ctrl[2] ? {16'd0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign be0    = be_wide[3:0];
  assign be1    = be_wide[7:4];
  assign wdata0 = wdata_wide[31:0];
  assign wdata1 = wdata_wide[63:32];
  assign split  = |be_wide[7:4];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute stage and word-organised data memory.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats instead of erroring.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state;
  logic              we_q;
  logic [2:0]        ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;

  logic              idle;
  logic [2:0]        al_ctrl;
  logic [1:0]        al_off;
  logic [DATA_W-1:0] al_wdata, rd_lo, rd_hi;
  logic [3:0]        al_be0, al_be1;
  logic [DATA_W-1:0] al_wdata0, al_wdata1, al_load;
  logic              al_split;
  logic              misalign_err;
  logic [ADDR_W-1:0] word0, word1;

  // In IDLE the shifter sees the incoming request so beat 0 can be registered at accept.
  assign idle     = (state == S_IDLE);
  assign al_ctrl  = idle ? req_ctrl      : ctrl_q;
  assign al_off   = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_wdata = idle ? req_wdata     : wdata_q;
  assign rd_lo    = (state == S_WAIT1) ? rdata0_q  : mem_rdata;
  assign rd_hi    = (state == S_WAIT1) ? mem_rdata : '0;
  assign word0    = {addr_q[ADDR_W-1:2], 2'b00};
  assign word1    = word0 + ADDR_W'(4);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign misalign_err = 1'b0;
`else
  logic [2:0] req_nbytes;
  assign req_nbytes   = size_bytes(req_ctrl);
  assign misalign_err = ((req_nbytes == 3'd2) && req_addr[0]) ||
                        ((req_nbytes == 3'd4) && (req_addr[1:0] != 2'b00));
`endif

  lsu_align u_align (
    .ctrl      (al_ctrl),
    .offset    (al_off),
    .wdata     (al_wdata),
    .rdata_lo  (rd_lo),
    .rdata_hi  (rd_hi),
    .be0       (al_be0),
    .be1       (al_be1),
    .wdata0    (al_wdata0),
    .wdata1    (al_wdata1),
    .split     (al_split),
    .load_data (al_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      ctrl_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            ctrl_q    <= req_ctrl;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (!ctrl_legal(req_ctrl, req_we) || misalign_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= al_be0;
              mem_wdata <= req_we ? al_wdata0 : '0;
              state     <= S_REQ0;
            end
          end
        end
        S_REQ0: begin
          if (mem_gnt) begin
            if (we_q && al_split) begin
              mem_addr  <= word1;
              mem_be    <= al_be1;
              mem_wdata <= al_wdata1;
              state     <= S_REQ1;
            end else begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_be    <= '0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              rsp_valid <= we_q;
              state     <= we_q ? S_RESP : S_WAIT0;
            end
          end
        end
        S_WAIT0: begin
          if (mem_rvalid) begin
            if (al_split) begin
              rdata0_q <= mem_rdata;
              mem_req  <= 1'b1;
              mem_addr <= word1;
              mem_be   <= al_be1;
              state    <= S_REQ1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= al_load;
              state     <= S_RESP;
            end
          end
        end
        S_REQ1: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= we_q;
            state     <= we_q ? S_RESP : S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (mem_rvalid) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= al_load;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized loads/stores
// against a byte-addressed memory model. Follows LSU_MISALIGN_SPLIT_EN if defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_ctrl   (req_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  ref_mem [256];
  logic [31:0] act_mem [64];

  // Responder knobs: 0 random grant/latency, 1 immediate grant, 2 grant after hold_cycles.
  int gnt_mode = 1;
  int hold_cycles = 0;
  int rv_fixed = 0;

  int          beats;
  logic [3:0]  beat_be [2];
  logic [31:0] beat_addr [2];
  logic [31:0] beat_wdata [2];
  int          stall_cnt = 0;
  int          stall_at_grant = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [4:0]  prev_webe;
  logic        pend = 1'b0;
  int          rv_wait = 0;
  logic [5:0]  pend_idx;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int sizeOf(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic refErr(input logic we, input logic [2:0] ctrl, input logic [31:0] addr);
    logic legal;
    legal = (ctrl == 3'd0 || ctrl == 3'd1 || ctrl == 3'd2) || (!we && (ctrl == 3'd4 || ctrl == 3'd5));
`ifdef LSU_MISALIGN_SPLIT_EN
    return !legal;
`else
    return !legal || ((int'(addr[1:0]) % sizeOf(ctrl)) != 0);
`endif
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] ctrl, input logic [31:0] addr);
    logic [31:0] v = '0;
    int n = sizeOf(ctrl);
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(int'(addr[7:0]) + i) & 255]) << (8 * i));
    if (!ctrl[2] && n < 4 && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic setWord(input int byte_addr, input logic [31:0] value);
    act_mem[byte_addr / 4] = value;
    for (int i = 0; i < 4; i++) ref_mem[byte_addr + i] = value[8*i +: 8];
  endtask

  // Memory side: grants, write application, read returns and stall stability checks.
  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        prev_stall = 1'b0;
        stall_cnt = 0;
        continue;
      end
      if (pend) begin
        if (rv_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = act_mem[pend_idx];
          pend = 1'b0;
        end else begin
          rv_wait--;
        end
      end else if (mem_req) begin
        logic give;
        if (prev_stall) begin
          checkOutput("hold_addr", mem_addr, prev_addr);
          checkOutput("hold_we_be", 32'({mem_we, mem_be}), 32'(prev_webe));
          checkOutput("hold_wdata", mem_wdata, prev_wdata);
        end
        if (gnt_mode == 0)      give = ($urandom_range(0, 1) == 0);
        else if (gnt_mode == 1) give = 1'b1;
        else                    give = (stall_cnt >= hold_cycles);
        if (give) begin
          mem_gnt = 1'b1;
          if (beats < 2) begin
            beat_be[beats]    = mem_be;
            beat_addr[beats]  = mem_addr;
            beat_wdata[beats] = mem_wdata;
          end
          beats++;
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) act_mem[mem_addr[7:2]][8*i +: 8] = mem_wdata[8*i +: 8];
          end else begin
            pend = 1'b1;
            pend_idx = mem_addr[7:2];
            rv_wait = (gnt_mode == 0) ? int'($urandom_range(0, 3)) : rv_fixed;
          end
          stall_at_grant = stall_cnt;
          stall_cnt = 0;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_addr = mem_addr;
          prev_webe = {mem_we, mem_be};
          prev_wdata = mem_wdata;
          stall_cnt++;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_beats, n, guard;
    n = sizeOf(ctrl);
    exp_err = refErr(we, ctrl, addr);
    exp_rdata = (we || exp_err) ? 32'd0 : refLoad(ctrl, addr);
    exp_beats = exp_err ? 0 : ((int'(addr[1:0]) + n > 4) ? 2 : 1);
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
    beats = 0;
    req_valid = 1'b1;
    req_we = we;
    req_ctrl = ctrl;
    req_addr = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    if (!rsp_valid) begin
      checkOutput("rsp_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("rsp_err", 32'(err), 32'(exp_err));
      checkOutput("rsp_rdata", rdata, exp_rdata);
      checkOutput("mem_beats", beats, exp_beats);
      if (we && !exp_err)
        for (int i = 0; i < n; i++) ref_mem[(int'(addr[7:0]) + i) & 255] = wdata[8*i +: 8];
      @(negedge clk);
      checkOutput("rsp_pulse", 32'({rsp_valid, req_ready}), 32'd1);
    end
  endtask

  logic [2:0]  ctrl_list [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_ctrl = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int w = 0; w < 64; w++) setWord(4 * w, $urandom);
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", 32'({req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be}), 32'h100);
    checkOutput("reset_addr", mem_addr, 32'd0);
    checkOutput("reset_wdata", mem_wdata, 32'd0);
    checkOutput("reset_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    gnt_mode = 1;
    rv_fixed = 0;
    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    checkOutput("sw_addr", beat_addr[0], 32'h10);
    checkOutput("sw_be", 32'(beat_be[0]), 32'hF);
    checkOutput("sw_wdata", beat_wdata[0], 32'hDEAD_BEEF);
    checkOutput("sw_latency", lat, 2);

    setWord(32'h10, 32'h8011_2233);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'd0, rd, er, lat);
    checkOutput("lb_value", rd, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'd0, rd, er, lat);
    checkOutput("lbu_value", rd, 32'h0000_0080);

    applyStimulus(1'b1, 3'b001, 32'h22, 32'h0000_1234, rd, er, lat);
    checkOutput("sh_addr", beat_addr[0], 32'h20);
    checkOutput("sh_be", 32'(beat_be[0]), 32'hC);
    checkOutput("sh_wdata", beat_wdata[0], 32'h1234_0000);

    setWord(32'h04, 32'hBBAA_0000);
    setWord(32'h08, 32'h0000_DDCC);
    applyStimulus(1'b0, 3'b010, 32'h06, 32'd0, rd, er, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("lw_split_rdata", rd, 32'hDDCC_BBAA);
    checkOutput("lw_split_be0", 32'(beat_be[0]), 32'hC);
    checkOutput("lw_split_be1", 32'(beat_be[1]), 32'h3);
    checkOutput("lw_split_addr1", beat_addr[1], 32'h08);
`else
    checkOutput("lw_misalign_err", 32'(er), 32'd1);
`endif

    applyStimulus(1'b0, 3'b011, 32'h40, 32'd0, rd, er, lat);
    checkOutput("illegal_err", 32'(er), 32'd1);
    checkOutput("illegal_latency", lat, 1);
    applyStimulus(1'b1, 3'b100, 32'h41, 32'h55, rd, er, lat);
    checkOutput("sbu_err", 32'(er), 32'd1);
    checkOutput("sbu_latency", lat, 1);

    gnt_mode = 2;
    hold_cycles = 5;
    applyStimulus(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, rd, er, lat);
    checkOutput("stall_cycles", stall_at_grant, 5);
    checkOutput("stall_latency", lat, 7);

    // Reset while a load waits for read data, then a fresh load must work.
    gnt_mode = 1;
    rv_fixed = 50;
    beats = 0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_ctrl = 3'b010;
    req_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int g = 0; g < 20 && !pend; g++) @(negedge clk);
    checkOutput("wait0_reached", 32'(pend), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", 32'({req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_be}), 32'h100);
    checkOutput("async_rst_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_fixed = 0;
    @(negedge clk);
    applyStimulus(1'b0, 3'b010, 32'h00, 32'd0, rd, er, lat);

    gnt_mode = 0;
    for (int t = 0; t < 200; t++) begin
      logic        we;
      logic [2:0]  ctrl;
      int          sel;
      we = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      ctrl = (sel < 9) ? ctrl_list[sel % 5] : 3'($urandom_range(0, 7));
      applyStimulus(we, ctrl, 32'($urandom_range(0, 247)), $urandom, rd, er, lat);
    end

    for (int w = 0; w < 64; w++)
      checkOutput("mem_word", act_mem[w],
                  {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
